// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
// Holds FSM states, the per-cycle action encoding and parameter helpers.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

    typedef enum logic [2:0] {
        ACT_HOLD, ACT_HALT, ACT_RET, ACT_CALL, ACT_ABS, ACT_REL, ACT_INC
    } action_t;

    // ProgSel width; a single-program build still gets a 1-bit select.
    function automatic int sel_w(input int nprog);
        return (nprog > 1) ? $clog2(nprog) : 1;
    endfunction

    // Default entry table, entry k at bits [k*t +: t]; covers NPROG*T <= 4096.
    function automatic logic [4095:0] default_start(input int t, input int nprog);
        logic [4095:0] v;
        int            val;
        v = '0;
        for (int k = 0; k < nprog; k++) begin
            val = k * ((1 << t) / nprog);
            for (int b = 0; b < t; b++) begin
                v[k*t + b] = val[b];
            end
        end
        return v;
    endfunction

    function automatic action_t decode_action(
        input logic stall, input logic halt, input logic ret, input logic call,
        input logic babs, input logic brel, input logic flag
    );
        if (stall)              return ACT_HOLD;
        else if (halt)          return ACT_HALT;
        else if (ret)           return ACT_RET;
        else if (call)          return ACT_CALL;
        else if (babs && flag)  return ACT_ABS;
        else if (brel && flag)  return ACT_REL;
        else                    return ACT_INC;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Synchronous return-address LIFO with clear; push-on-full and pop-on-empty are ignored.
// The parent decides when either case is an error.
module ret_stack #(
    parameter int W = 10,
    parameter int D = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [W-1:0]         data_i,
    output logic [W-1:0]         top_o,
    output logic [$clog2(D):0]   depth_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [AW:0]   depth_q;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign wr_idx  = depth_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign full_o  = (depth_q == (AW+1)'(D));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;
    assign top_o   = mem_q[top_idx];

    always_ff @(posedge Clk) begin
        if (Reset || clear_i) begin
            depth_q <= '0;
        end else if (push_i && !full_o) begin
            depth_q <= depth_q + (AW+1)'(1);
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - (AW+1)'(1);
        end
    end

    // Contents need no reset: depth alone defines what is valid.
    always_ff @(posedge Clk) begin
        if (!Reset && !clear_i && push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/inst_fetch_rs.sv
// Program counter / fetch sequencer with start table, return stack, stall and halt.
// All outputs registered; a control input changes ProgCtr one cycle later.
module inst_fetch_rs
    import fetch_pkg::*;
#(
    parameter int T     = 10,
    parameter int D     = 4,
    parameter int NPROG = 4,
    parameter logic [NPROG-1:0][T-1:0] START_ADDR = (NPROG*T)'(default_start(T, NPROG))
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [sel_w(NPROG)-1:0]    ProgSel,
    input  logic                       Stall,
    input  logic                       BranchAbs,
    input  logic                       BranchRel,
    input  logic                       Call,
    input  logic                       Ret,
    input  logic                       Halt,
    input  logic                       AluFlag,
    input  logic [T-1:0]               Target,
    output logic [T-1:0]               ProgCtr,
    output logic                       Done,
    output logic [$clog2(D):0]         StackDepth,
    output logic                       StackErr
);
    fetch_state_t state_q, state_d;
    logic [T-1:0] pc_q, pc_d;
    logic         err_q, err_d;
    logic         done_q, done_d;

    action_t      act;
    logic [T-1:0] pc_inc, pc_rel, start_pc;
    logic         stk_push, stk_pop, stk_clear;
    logic [T-1:0] stk_top;
    logic         stk_full, stk_empty;

    assign pc_inc   = pc_q + T'(1);
    assign pc_rel   = pc_q + Target;
    // Out-of-range selects fall back to program 0.
    assign start_pc = (int'(ProgSel) < NPROG) ? START_ADDR[ProgSel] : START_ADDR[0];
    assign act      = decode_action(Stall, Halt, Ret, Call, BranchAbs, BranchRel, AluFlag);

    ret_stack #(.W(T), .D(D)) u_stack (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear_i (stk_clear),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .depth_o (StackDepth),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        err_d     = err_q;
        done_d    = done_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        if (Start) begin
            state_d   = IDLE;
            pc_d      = start_pc;
            err_d     = 1'b0;
            done_d    = 1'b0;
            stk_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    case (act)
                        ACT_HOLD: ;
                        ACT_HALT: begin
                            state_d = HALTED;
                            done_d  = 1'b1;
                        end
                        ACT_RET: begin
                            if (!stk_empty) begin
                                pc_d    = stk_top;
                                stk_pop = 1'b1;
                            end else begin
                                err_d = 1'b1;
                                pc_d  = pc_inc;
                            end
                        end
                        ACT_CALL: begin
                            if (!stk_full) begin
                                stk_push = 1'b1;
                                pc_d     = Target;
                            end else begin
                                err_d = 1'b1;
                                pc_d  = pc_inc;
                            end
                        end
                        ACT_ABS: pc_d = Target;
                        ACT_REL: pc_d = pc_rel;
                        default: pc_d = pc_inc;
                    endcase
                end
                HALTED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign Done     = done_q;
    assign StackErr = err_q;

endmodule

// File: tb/tb_inst_fetch_rs.sv
// Directed bench for inst_fetch_rs with default parameters (T=10, D=4, NPROG=4).
module tb_inst_fetch_rs;
    logic       Clk = 1'b0;
    logic       Reset, Start, Stall, BranchAbs, BranchRel, Call, Ret, Halt, AluFlag;
    logic [1:0] ProgSel;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic       Done, StackErr;
    logic [2:0] StackDepth;

    int errors = 0;
    int checks = 0;

    inst_fetch_rs dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Call(Call), .Ret(Ret),
        .Halt(Halt), .AluFlag(AluFlag), .Target(Target), .ProgCtr(ProgCtr),
        .Done(Done), .StackDepth(StackDepth), .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [9:0] pc, input logic [2:0] dep,
                           input logic err, input logic done);
        chk({tag, ".pc"},   16'(ProgCtr),    16'(pc));
        chk({tag, ".dep"},  16'(StackDepth), 16'(dep));
        chk({tag, ".err"},  16'(StackErr),   16'(err));
        chk({tag, ".done"}, 16'(Done),       16'(done));
    endtask

    initial begin
        Reset = 1; Start = 0; ProgSel = 0; Stall = 0; BranchAbs = 0; BranchRel = 0;
        Call = 0; Ret = 0; Halt = 0; AluFlag = 0; Target = '0;
        step(); step();
        chk_all("reset", 10'h000, 3'd0, 1'b0, 1'b0);

        // Start program 2 held for three cycles
        Reset = 0; Start = 1; ProgSel = 2;
        step(); chk("start1", 16'(ProgCtr), 16'h200);
        step(); step(); chk("start3", 16'(ProgCtr), 16'h200);
        Start = 0;
        step(); chk("run_entry", 16'(ProgCtr), 16'h200);
        step(); chk("inc1", 16'(ProgCtr), 16'h201);
        step(); chk("inc2", 16'(ProgCtr), 16'h202);

        // Call / return
        BranchAbs = 1; AluFlag = 1; Target = 10'h010;
        step(); chk("abs_010", 16'(ProgCtr), 16'h010);
        BranchAbs = 0; Call = 1; Target = 10'h080;
        step(); chk("call.pc", 16'(ProgCtr), 16'h080); chk("call.dep", 16'(StackDepth), 16'd1);
        Call = 0;
        step(); chk("sub1", 16'(ProgCtr), 16'h081);
        step(); chk("sub2", 16'(ProgCtr), 16'h082);
        step(); chk("sub3", 16'(ProgCtr), 16'h083);
        Ret = 1;
        step(); chk("ret.pc", 16'(ProgCtr), 16'h011); chk("ret.dep", 16'(StackDepth), 16'd0);
        Ret = 0;

        // Branches and wrap
        BranchAbs = 1; Target = 10'h020;
        step();
        BranchAbs = 0; BranchRel = 1; Target = 10'h3FC;
        step(); chk("rel_neg", 16'(ProgCtr), 16'h01C);
        BranchRel = 0; BranchAbs = 1; Target = 10'h020;
        step();
        BranchAbs = 0; BranchRel = 1; AluFlag = 0; Target = 10'h3FC;
        step(); chk("rel_notaken", 16'(ProgCtr), 16'h021);
        BranchRel = 0; BranchAbs = 1; AluFlag = 1; Target = 10'h3FF;
        step(); chk("abs_3ff", 16'(ProgCtr), 16'h3FF);
        BranchAbs = 0;
        step(); chk("wrap", 16'(ProgCtr), 16'h000);
        BranchAbs = 1; Target = 10'h3FF;
        step();
        BranchAbs = 0; Call = 1; Target = 10'h050;
        step(); chk("call_top.pc", 16'(ProgCtr), 16'h050);
        Call = 0; Ret = 1;
        step(); chk("ret_wrap", 16'(ProgCtr), 16'h000);
        Ret = 0;

        // Overflow: four calls fill the stack, fifth errors
        Call = 1; Target = 10'h100;
        step(); step(); step(); step();
        chk_all("full", 10'h100, 3'd4, 1'b0, 1'b0);
        step();
        chk_all("overflow", 10'h101, 3'd4, 1'b1, 1'b0);
        Call = 0;

        // Underflow after reset
        Reset = 1;
        step();
        Reset = 0;
        step(); chk("rst_idle_hold", 16'(ProgCtr), 16'h000);
        Ret = 1;
        step();
        chk_all("underflow", 10'h001, 3'd0, 1'b1, 1'b0);
        Ret = 0;
        step(); chk("err_sticky", 16'(StackErr), 16'd1);

        // Start clears the error and reloads program 1
        Start = 1; ProgSel = 1;
        step();
        chk_all("start_p1", 10'h100, 3'd0, 1'b0, 1'b0);
        Start = 0;
        step();

        // Stall masks Call, then Call runs; Halt beats Ret
        Stall = 1; Call = 1; Target = 10'h040;
        step(); step();
        chk_all("stall", 10'h100, 3'd0, 1'b0, 1'b0);
        Stall = 0;
        step();
        chk_all("unstall_call", 10'h040, 3'd1, 1'b0, 1'b0);
        Call = 0; Halt = 1; Ret = 1;
        step();
        chk_all("halt", 10'h040, 3'd1, 1'b0, 1'b1);
        Halt = 0; Ret = 0; BranchAbs = 1; Target = 10'h222;
        step();
        chk_all("halted_hold", 10'h040, 3'd1, 1'b0, 1'b1);
        BranchAbs = 0;

        // Reset mid-run with depth 3
        Start = 1; ProgSel = 0;
        step();
        chk_all("start_p0", 10'h000, 3'd0, 1'b0, 1'b0);
        Start = 0;
        step();
        Call = 1; Target = 10'h100;
        step(); step(); step();
        chk("depth3", 16'(StackDepth), 16'd3);
        Call = 0; Reset = 1;
        step();
        chk_all("mid_reset", 10'h000, 3'd0, 1'b0, 1'b0);
        Reset = 0;
        step(); chk("post_rst_idle", 16'(ProgCtr), 16'h000);
        step(); chk("post_rst_run", 16'(ProgCtr), 16'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
